// File: rtl/wvb_readout_arbiter_pkg.sv
// Shared definitions for the waveform-buffer readout arbiter: state encoding
// and the helpers that locate the end-of-event flag and the runaway limit.
package wvb_readout_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD,
    ST_CAP,
    ST_SEND,
    ST_DONE
  } state_t;

  function automatic int eoe_bit(input int data_width);
    return data_width - 1;
  endfunction

  function automatic int runaway_limit(input int len_width);
    return 1 << len_width;
  endfunction

endpackage

// File: rtl/wvb_readout_arbiter_if.sv
// Downstream packet stream shared by all channels: latched header, source
// channel, and one word per valid/ready handshake with sop/eop framing.
interface wvb_readout_arbiter_if #(
  parameter int P_N_CHAN     = 4,
  parameter int P_DATA_WIDTH = 22,
  parameter int P_HDR_WIDTH  = 160
);
  localparam int CHAN_W = $clog2(P_N_CHAN);

  logic [P_HDR_WIDTH-1:0]  out_hdr;
  logic [CHAN_W-1:0]       out_chan;
  logic [P_DATA_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sop;
  logic                    out_eop;

  modport master (
    output out_hdr, out_chan, out_data, out_valid, out_sop, out_eop,
    input  out_ready
  );

  modport slave (
    input  out_hdr, out_chan, out_data, out_valid, out_sop, out_eop,
    output out_ready
  );

endinterface

// File: rtl/wvb_readout_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from the channel after rr_ptr
// and returns the first requesting index.
module rr_arbiter #(
  parameter int P_N_CHAN = 4
) (
  input  logic [P_N_CHAN-1:0]         req,
  input  logic [$clog2(P_N_CHAN)-1:0] rr_ptr,
  output logic                        grant_valid,
  output logic [$clog2(P_N_CHAN)-1:0] grant
);
  localparam int IDX_W = $clog2(P_N_CHAN);

  int idx;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int k = 1; k <= P_N_CHAN; k++) begin
      idx = (int'(rr_ptr) + k) % P_N_CHAN;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/wvb_readout_arbiter.sv
// Round-robin readout controller: grants one waveform-buffer channel per
// event, pops its header and streams its words until end-of-event.
module wvb_readout_arbiter
  import wvb_readout_arbiter_pkg::*;
#(
  parameter int P_N_CHAN        = 4,
  parameter int P_DATA_WIDTH    = 22,
  parameter int P_HDR_WIDTH     = 160,
  parameter int P_MAX_LEN_WIDTH = 12
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic [P_N_CHAN-1:0]               chan_mask,
  input  logic [P_N_CHAN-1:0]               hdr_empty,
  input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]   hdr_data,
  input  logic [P_N_CHAN*P_DATA_WIDTH-1:0]  wvb_data,
  output logic [P_N_CHAN-1:0]               hdr_rdreq,
  output logic [P_N_CHAN-1:0]               wvb_rdreq,
  output logic [P_N_CHAN-1:0]               wvb_rddone,
  wvb_readout_arbiter_if.master             ob,
  output logic                              busy,
  output logic                              len_err,
  output logic [31:0]                       pkt_cnt
);
  localparam int CHAN_W  = $clog2(P_N_CHAN);
  localparam int EOE_BIT = eoe_bit(P_DATA_WIDTH);
  localparam logic [P_MAX_LEN_WIDTH-1:0] LAST_IDX =
    P_MAX_LEN_WIDTH'(runaway_limit(P_MAX_LEN_WIDTH) - 1);

  state_t                    state, next_state;
  logic [CHAN_W-1:0]         rr_ptr;
  logic [P_MAX_LEN_WIDTH-1:0] word_cnt;
  logic                      first;

  logic [P_N_CHAN-1:0]       eligible;
  logic                      grant_valid;
  logic [CHAN_W-1:0]         grant;
  logic [P_N_CHAN-1:0]       sel_onehot;
  logic [P_DATA_WIDTH-1:0]   cur_word;
  logic                      cur_eoe;
  logic                      at_limit;
  logic                      handshake;

  assign eligible   = ~hdr_empty & ~chan_mask;
  assign sel_onehot = {{(P_N_CHAN-1){1'b0}}, 1'b1} << ob.out_chan;
  assign cur_word   = wvb_data[ob.out_chan*P_DATA_WIDTH +: P_DATA_WIDTH];
  assign cur_eoe    = cur_word[EOE_BIT];
  assign at_limit   = (word_cnt == LAST_IDX);
  assign handshake  = ob.out_valid && ob.out_ready;
  assign busy       = (state != ST_IDLE);

  rr_arbiter #(
    .P_N_CHAN (P_N_CHAN)
  ) u_rr (
    .req         (eligible),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Strobes are decoded from state so a reset clears them in the same instant.
  always_comb begin
    next_state = state;
    hdr_rdreq  = '0;
    wvb_rdreq  = '0;
    wvb_rddone = '0;
    case (state)
      ST_IDLE: if (en && grant_valid) next_state = ST_HDR;
      ST_HDR: begin
        hdr_rdreq  = sel_onehot;
        next_state = ST_RD;
      end
      ST_RD: begin
        wvb_rdreq  = sel_onehot;
        next_state = ST_CAP;
      end
      ST_CAP: next_state = ST_SEND;
      ST_SEND: if (handshake) next_state = ob.out_eop ? ST_DONE : ST_RD;
      ST_DONE: begin
        wvb_rddone = sel_onehot;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= CHAN_W'(P_N_CHAN - 1);
      word_cnt     <= '0;
      first        <= 1'b0;
      ob.out_hdr   <= '0;
      ob.out_chan  <= '0;
      ob.out_data  <= '0;
      ob.out_valid <= 1'b0;
      ob.out_sop   <= 1'b0;
      ob.out_eop   <= 1'b0;
      len_err      <= 1'b0;
      pkt_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en && grant_valid) begin
            ob.out_chan <= grant;
            ob.out_hdr  <= hdr_data[grant*P_HDR_WIDTH +: P_HDR_WIDTH];
            rr_ptr      <= grant;
          end
        end
        ST_HDR: begin
          word_cnt <= '0;
          first    <= 1'b1;
        end
        // A word without EOE at the last counter value closes the packet anyway.
        ST_CAP: begin
          ob.out_data  <= cur_word;
          ob.out_valid <= 1'b1;
          ob.out_sop   <= first;
          ob.out_eop   <= cur_eoe || at_limit;
          if (!cur_eoe && at_limit) len_err <= 1'b1;
        end
        ST_SEND: begin
          if (handshake) begin
            ob.out_valid <= 1'b0;
            ob.out_sop   <= 1'b0;
            ob.out_eop   <= 1'b0;
            first        <= 1'b0;
            word_cnt     <= word_cnt + 1'b1;
          end
        end
        ST_DONE: pkt_cnt <= pkt_cnt + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wvb_readout_arbiter.sv
// Directed bench for wvb_readout_arbiter with a behavioural model of the
// four waveform buffers and a log of every accepted output word.
module tb_wvb_readout_arbiter;
  localparam int N  = 4;
  localparam int DW = 22;
  localparam int HW = 32;
  localparam int LW = 4;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [N-1:0]      chan_mask;
  logic [N-1:0]      hdr_empty;
  logic [N*HW-1:0]   hdr_data;
  logic [N*DW-1:0]   wvb_data;
  logic [N-1:0]      hdr_rdreq, wvb_rdreq, wvb_rddone;
  logic              busy, len_err;
  logic [31:0]       pkt_cnt;

  wvb_readout_arbiter_if #(.P_N_CHAN(N), .P_DATA_WIDTH(DW), .P_HDR_WIDTH(HW)) ob ();

  wvb_readout_arbiter #(
    .P_N_CHAN(N), .P_DATA_WIDTH(DW), .P_HDR_WIDTH(HW), .P_MAX_LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .chan_mask(chan_mask),
    .hdr_empty(hdr_empty), .hdr_data(hdr_data), .wvb_data(wvb_data),
    .hdr_rdreq(hdr_rdreq), .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone),
    .ob(ob), .busy(busy), .len_err(len_err), .pkt_cnt(pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: bench pushes (pushed/wptr), model pops on strobes.
  logic [HW-1:0] hdr_mem  [N][16];
  logic [DW-1:0] word_mem [N][128];
  logic [DW-1:0] wreg [N];
  int pushed [N];
  int wptr   [N];
  int popped [N];
  int rptr   [N];
  int npop   [N];
  int nrd    [N];
  int ndone  [N];

  for (genvar g = 0; g < N; g++) begin : g_buf
    assign hdr_empty[g]             = (popped[g] == pushed[g]);
    assign hdr_data[g*HW +: HW]     = hdr_mem[g][popped[g] % 16];
    assign wvb_data[g*DW +: DW]     = wreg[g];
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        popped[i] <= pushed[i];
        rptr[i]   <= wptr[i];
        wreg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (hdr_rdreq[i]) begin
          popped[i] <= popped[i] + 1;
          npop[i]   <= npop[i] + 1;
        end
        if (wvb_rdreq[i]) begin
          wreg[i] <= word_mem[i][rptr[i] % 128];
          rptr[i] <= rptr[i] + 1;
          nrd[i]  <= nrd[i] + 1;
        end
        if (wvb_rddone[i]) ndone[i] <= ndone[i] + 1;
      end
    end
  end

  typedef struct {
    logic [1:0]    chan;
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } ent_t;

  ent_t log_q[$];
  int   n_pkt = 0;
  int   viol  = 0;

  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      if (ob.out_valid && ob.out_ready) begin
        e.chan = ob.out_chan; e.hdr = ob.out_hdr; e.data = ob.out_data;
        e.sop  = ob.out_sop;  e.eop = ob.out_eop;
        log_q.push_back(e);
        if (ob.out_eop) n_pkt++;
      end
      if ($countones(hdr_rdreq) > 1 || $countones(wvb_rdreq) > 1 ||
          $countones(wvb_rddone) > 1) viol++;
      if (ob.out_valid && !ob.out_ready && (|wvb_rdreq)) viol++;
    end
  end

  int vecs = 0;
  int miscompares = 0;
  int ev_ctr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mkword(int ch, int ev, int k, bit eoe);
    return {eoe, 3'(ch), 10'(ev), 8'(k)};
  endfunction

  function automatic logic [HW-1:0] mkhdr(int ch, int ev);
    return {8'hA5, 8'(ch), 16'(ev)};
  endfunction

  task automatic push_event(input int ch, input int nw, input bit eoe_last, output int ev);
    ev = ev_ctr;
    ev_ctr++;
    for (int k = 0; k < nw; k++) begin
      word_mem[ch][wptr[ch] % 128] = mkword(ch, ev, k, eoe_last && (k == nw - 1));
      wptr[ch]++;
    end
    hdr_mem[ch][pushed[ch] % 16] = mkhdr(ch, ev);
    pushed[ch]++;
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int c;
    c = 0;
    while (n_pkt < target && c < budget) begin tick; c++; end
    chk("packets_completed", 64'(n_pkt), 64'(target));
    c = 0;
    while (busy && c < 20) begin tick; c++; end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  typedef struct {
    logic [N-1:0]    push;
    logic [N-1:0]    mask;
    int              n;
    logic [4:0][1:0] exp;
  } vec_t;

  vec_t vt[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev, ev2, b, p0, lat, c;
    int snap [N];

    vt[0] = '{push: 4'b0110, mask: 4'b0010, n: 1, exp: {2'd0, 2'd0, 2'd0, 2'd0, 2'd2}};
    vt[1] = '{push: 4'b0000, mask: 4'b0000, n: 1, exp: {2'd0, 2'd0, 2'd0, 2'd0, 2'd1}};
    vt[2] = '{push: 4'b1001, mask: 4'b0000, n: 2, exp: {2'd0, 2'd0, 2'd0, 2'd0, 2'd3}};
    vt[3] = '{push: 4'b1111, mask: 4'b0101, n: 2, exp: {2'd0, 2'd0, 2'd0, 2'd3, 2'd1}};
    vt[4] = '{push: 4'b0000, mask: 4'b0000, n: 2, exp: {2'd0, 2'd0, 2'd0, 2'd2, 2'd0}};

    for (int i = 0; i < N; i++) begin
      pushed[i] = 0; wptr[i] = 0;
    end
    rst_n = 1'b0; en = 1'b0; chan_mask = '0; ob.out_ready = 1'b0;
    repeat (3) tick;

    chk("reset_busy",      64'(busy), 0);
    chk("reset_out_valid", 64'(ob.out_valid), 0);
    chk("reset_out_hdr",   64'(ob.out_hdr), 0);
    chk("reset_pkt_cnt",   64'(pkt_cnt), 0);
    chk("reset_len_err",   64'(len_err), 0);
    chk("reset_strobes",   64'({hdr_rdreq, wvb_rdreq, wvb_rddone}), 0);
    rst_n = 1'b1;
    tick;

    // Single 3-word event on ch1
    ob.out_ready = 1'b1;
    b = log_q.size();
    push_event(1, 3, 1'b1, ev);
    en = 1'b1;
    c = 0;
    while (!busy && c < 20) begin tick; c++; end
    lat = 0;
    while (!ob.out_valid && lat < 20) begin tick; lat++; end
    chk("t1_first_word_latency", 64'(lat), 3);
    wait_pkts(1, 100);
    chk("t1_word_count", 64'(log_q.size() - b), 3);
    for (int k = 0; k < 3; k++) begin
      if (b + k < log_q.size()) begin
        chk("t1_data",    64'(log_q[b+k].data), 64'(mkword(1, ev, k, k == 2)));
        chk("t1_sop_eop", 64'({log_q[b+k].sop, log_q[b+k].eop}), 64'({k == 0, k == 2}));
        chk("t1_chan",    64'(log_q[b+k].chan), 1);
        chk("t1_hdr",     64'(log_q[b+k].hdr), 64'(mkhdr(1, ev)));
      end
    end
    chk("t1_hdr_pops",  64'(npop[1]), 1);
    chk("t1_wvb_reads", 64'(nrd[1]), 3);
    chk("t1_rddone",    64'(ndone[1]), 1);
    chk("t1_pkt_cnt",   64'(pkt_cnt), 1);
    chk("t1_out_chan",  64'(ob.out_chan), 1);

    // Round robin from reset with ch0 refilled while ch1 is served
    en = 1'b0;
    do_reset;
    p0 = n_pkt;
    b  = log_q.size();
    for (int ch = 0; ch < N; ch++) push_event(ch, 1, 1'b1, ev);
    en = 1'b1;
    c = 0;
    while (!(busy && ob.out_chan == 2'd1) && c < 100) begin tick; c++; end
    chk("rr_reached_ch1", 64'(busy && ob.out_chan == 2'd1), 1);
    push_event(0, 1, 1'b1, ev);
    wait_pkts(p0 + 5, 300);
    for (int j = 0; j < 5; j++) begin
      if (b + j < log_q.size())
        chk("rr_order", 64'(log_q[b+j].chan), 64'((j == 4) ? 0 : j));
    end
    chk("rr_pkt_cnt", 64'(pkt_cnt), 5);

    // Table of arbitration vectors, continuing from rr_ptr = 0
    for (int v = 0; v < 5; v++) begin
      p0 = n_pkt;
      b  = log_q.size();
      for (int ch = 0; ch < N; ch++) snap[ch] = npop[ch];
      chan_mask = vt[v].mask;
      for (int ch = 0; ch < N; ch++) if (vt[v].push[ch]) push_event(ch, 1, 1'b1, ev);
      wait_pkts(p0 + vt[v].n, 200);
      repeat (8) tick;
      chk("vec_pkt_count", 64'(n_pkt - p0), 64'(vt[v].n));
      for (int j = 0; j < vt[v].n; j++) begin
        if (b + j < log_q.size()) begin
          chk("vec_grant",    64'(log_q[b+j].chan), 64'(vt[v].exp[j]));
          chk("vec_sop_eop",  64'({log_q[b+j].sop, log_q[b+j].eop}), 64'(2'b11));
          chk("vec_hdr_chan", 64'(log_q[b+j].hdr[23:16]), 64'(vt[v].exp[j]));
        end
      end
      for (int ch = 0; ch < N; ch++)
        if (vt[v].mask[ch]) chk("vec_masked_no_pop", 64'(npop[ch]), 64'(snap[ch]));
    end
    chan_mask = '0;

    // Back-pressure: ready high one cycle in four on a 5-word event
    p0 = n_pkt;
    b  = log_q.size();
    push_event(2, 5, 1'b1, ev);
    for (int k = 0; k < 400 && n_pkt == p0; k++) begin
      ob.out_ready = ((k % 4) == 3);
      tick;
    end
    ob.out_ready = 1'b1;
    chk("bp_pkt_done", 64'(n_pkt), 64'(p0 + 1));
    chk("bp_word_count", 64'(log_q.size() - b), 5);
    for (int k = 0; k < 5; k++) begin
      if (b + k < log_q.size()) begin
        chk("bp_data",    64'(log_q[b+k].data), 64'(mkword(2, ev, k, k == 4)));
        chk("bp_sop_eop", 64'({log_q[b+k].sop, log_q[b+k].eop}), 64'({k == 0, k == 4}));
      end
    end
    c = 0;
    while (busy && c < 20) begin tick; c++; end

    // Runaway event: 16 words without EOE, then a normal event
    p0 = n_pkt;
    b  = log_q.size();
    for (int ch = 0; ch < N; ch++) snap[ch] = ndone[ch];
    chk("run_len_err_before", 64'(len_err), 0);
    push_event(3, 16, 1'b0, ev);
    wait_pkts(p0 + 1, 300);
    chk("run_word_count", 64'(log_q.size() - b), 16);
    if (b + 15 < log_q.size()) begin
      chk("run_first_sop", 64'({log_q[b].sop, log_q[b].eop}), 64'(2'b10));
      chk("run_w15_eop",   64'(log_q[b+14].eop), 0);
      chk("run_w16_eop",   64'(log_q[b+15].eop), 1);
      chk("run_w16_data",  64'(log_q[b+15].data), 64'(mkword(3, ev, 15, 1'b0)));
    end
    chk("run_len_err",  64'(len_err), 1);
    chk("run_rddone",   64'(ndone[3] - snap[3]), 1);
    b = log_q.size();
    push_event(3, 2, 1'b1, ev2);
    wait_pkts(p0 + 2, 100);
    chk("run_next_count", 64'(log_q.size() - b), 2);
    for (int k = 0; k < 2; k++) begin
      if (b + k < log_q.size()) begin
        chk("run_next_data", 64'(log_q[b+k].data), 64'(mkword(3, ev2, k, k == 1)));
        chk("run_next_sop_eop", 64'({log_q[b+k].sop, log_q[b+k].eop}), 64'({k == 0, k == 1}));
      end
    end
    chk("run_len_err_sticky", 64'(len_err), 1);

    // Reset asserted while word 2 waits in SEND
    b = log_q.size();
    push_event(1, 3, 1'b1, ev);
    c = 0;
    while (log_q.size() == b && c < 50) begin tick; c++; end
    ob.out_ready = 1'b0;
    c = 0;
    while (!ob.out_valid && c < 20) begin tick; c++; end
    chk("rst_word2_pending", 64'({ob.out_valid, ob.out_sop}), 64'(2'b10));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(ob.out_valid), 0);
    chk("rst_out_data",  64'(ob.out_data), 0);
    chk("rst_out_hdr",   64'(ob.out_hdr), 0);
    chk("rst_out_chan",  64'(ob.out_chan), 0);
    chk("rst_sop_eop",   64'({ob.out_sop, ob.out_eop}), 0);
    chk("rst_busy",      64'(busy), 0);
    chk("rst_len_err",   64'(len_err), 0);
    chk("rst_pkt_cnt",   64'(pkt_cnt), 0);
    chk("rst_strobes",   64'({hdr_rdreq, wvb_rdreq, wvb_rddone}), 0);
    tick; tick;
    rst_n = 1'b1;
    ob.out_ready = 1'b1;
    p0 = n_pkt;
    b  = log_q.size();
    push_event(2, 1, 1'b1, ev);
    push_event(0, 1, 1'b1, ev);
    chk("rst_pkt_cnt_after", 64'(pkt_cnt), 0);
    wait_pkts(p0 + 2, 100);
    if (b + 1 < log_q.size()) begin
      chk("rst_first_grant",  64'(log_q[b].chan), 0);
      chk("rst_second_grant", 64'(log_q[b+1].chan), 2);
    end
    chk("rst_pkt_cnt_final", 64'(pkt_cnt), 2);

    chk("strobe_rules", 64'(viol), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
